// File: rtl/fir_pkg.sv
// Shared constants and types for the serial 64-tap FIR MAC core.
package fir_pkg;

  localparam int TAPS   = 64;
  localparam int DATA_W = 16;
  localparam int SUM_W  = 2 * DATA_W + $clog2(TAPS);
  localparam int PTR_W  = $clog2(TAPS);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic {
    LOAD    = 1'b0,
    COMPUTE = 1'b1
  } state_t;

  // Sign-extend a full-precision product into the accumulator width.
  function automatic logic signed [SUM_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/fir_mac_core_mac.sv
// Signed DATA_W x DATA_W multiplier feeding a SUM_W accumulator.
// acc_nxt exposes acc plus the current product so the final term can be
// captured into the result register on the same edge it is accumulated.
module fir_mac
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [SUM_W-1:0]  acc,
  output logic signed [SUM_W-1:0]  acc_nxt
);

  logic signed [PROD_W-1:0] prod;

  assign prod    = a * b;
  assign acc_nxt = acc + sext_prod(prod);

  // Accumulator: clear has priority over accumulate.
  always_ff @(posedge clk) begin
    if (!reset)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_nxt;
  end

endmodule

// File: rtl/fir_mac_core.sv
// 64-tap FIR output engine: load a frame of (X,B) pairs, then run one
// MAC per cycle over the buffer and register the dot product in sum.
// A single index walks the buffer for both loading and computing; it
// wraps to 0 at the end of each phase so the next phase starts at tap 0.
module fir_mac_core
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] X,
  input  logic signed [DATA_W-1:0] B,
  input  logic                     in_write_ctrlX,
  output logic                     able2write_out,
  output logic signed [SUM_W-1:0]  sum
);

  state_t                   state;
  logic [PTR_W-1:0]         wr_ptr;
  logic signed [DATA_W-1:0] x_mem [TAPS];
  logic signed [DATA_W-1:0] b_mem [TAPS];

  logic                     accept;
  logic                     last;
  logic                     mac_clr;
  logic                     mac_en;
  logic signed [SUM_W-1:0]  acc;
  logic signed [SUM_W-1:0]  acc_nxt;

  assign accept  = (state == LOAD) && in_write_ctrlX;
  assign last    = (wr_ptr == PTR_W'(TAPS-1));
  assign mac_clr = accept && last;
  assign mac_en  = (state == COMPUTE);

  // Pair storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      x_mem[wr_ptr] <= X;
      b_mem[wr_ptr] <= B;
    end
  end

  // Control FSM: index advance, phase switch and result capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= LOAD;
      wr_ptr         <= '0;
      able2write_out <= 1'b1;
      sum            <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (last) begin
              state          <= COMPUTE;
              able2write_out <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (last) begin
            sum            <= acc_nxt;
            state          <= LOAD;
            able2write_out <= 1'b1;
          end
        end
        default: begin
          state          <= LOAD;
          wr_ptr         <= '0;
          able2write_out <= 1'b1;
        end
      endcase
    end
  end

  fir_mac u_mac (
    .clk     (clk),
    .reset   (reset),
    .clr     (mac_clr),
    .en      (mac_en),
    .a       (x_mem[wr_ptr]),
    .b       (b_mem[wr_ptr]),
    .acc     (acc),
    .acc_nxt (acc_nxt)
  );

endmodule

// File: tb/tb_fir_mac_core.sv
// Directed bench for fir_mac_core: frames of hand-computed dot products,
// gaps, ignored strobes during compute, and reset aborts.
module tb_fir_mac_core;

  logic               clk;
  logic               reset;
  logic signed [15:0] X;
  logic signed [15:0] B;
  logic               in_write_ctrlX;
  logic               able2write_out;
  logic signed [37:0] sum;

  logic signed [15:0] xa [64];
  logic signed [15:0] ba [64];

  int total = 0;
  int bad   = 0;

  fir_mac_core dut (
    .clk            (clk),
    .reset          (reset),
    .X              (X),
    .B              (B),
    .in_write_ctrlX (in_write_ctrlX),
    .able2write_out (able2write_out),
    .sum            (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic signed [15:0] xv, input logic signed [15:0] bv);
    for (int i = 0; i < 64; i++) begin
      xa[i] = xv;
      ba[i] = bv;
    end
  endtask

  // Write all 64 pairs starting at a negedge; optional idle gap before pair gap_at.
  task automatic load(input int gap_at, input int gap_len);
    for (int i = 0; i < 64; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          in_write_ctrlX = 1'b0;
          X = 16'sd999;
          B = 16'sd999;
          @(negedge clk);
        end
      end
      X = xa[i];
      B = ba[i];
      in_write_ctrlX = 1'b1;
      @(negedge clk);
    end
    in_write_ctrlX = 1'b0;
    chk("able_low_after_e0", able2write_out, 0);
  endtask

  // Count compute cycles until able2write_out rises; checks sum holds mid-way.
  task automatic compute(input bit hold, input logic signed [63:0] old_sum, output int n);
    n = 0;
    while (n < 100) begin
      if (hold) begin
        in_write_ctrlX = 1'b1;
        X = 16'sd100;
        B = 16'sd100;
      end
      @(negedge clk);
      n++;
      if (n == 32) chk("sum_hold", sum, old_sum);
      if (able2write_out) break;
    end
    in_write_ctrlX = 1'b0;
  endtask

  task automatic frame(input string tag, input logic signed [63:0] exp, input int gap_at,
                       input int gap_len, input bit hold);
    int n;
    logic signed [63:0] old;
    old = sum;
    load(gap_at, gap_len);
    compute(hold, old, n);
    chk({tag, "_cycles"}, n, 64);
    chk({tag, "_able"}, able2write_out, 1);
    chk({tag, "_sum"}, sum, exp);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    in_write_ctrlX = 1'b1;
    X = 16'sd5;
    B = 16'sd5;
    repeat (6) @(negedge clk);
    chk("rst_sum", sum, 0);
    chk("rst_able", able2write_out, 1);
    reset = 1'b1;
    in_write_ctrlX = 1'b0;
    @(negedge clk);

    fill(16'sd1, 16'sd1);
    frame("ones", 64, -1, 0, 0);

    fill(16'sd32767, 16'sd32767);
    frame("maxmax", 64'sd68715282496, -1, 0, 0);
    fill(-16'sd32768, -16'sd32768);
    frame("minmin", 64'sd68719476736, -1, 0, 0);
    fill(-16'sd32768, 16'sd32767);
    frame("minmax", -64'sd68717379584, -1, 0, 0);

    fill(16'sd0, 16'sd0);
    for (int i = 0; i < 64; i++) ba[i] = 16'(i);
    xa[5] = 16'sd1;
    frame("imp5", 5, -1, 0, 0);
    xa[5] = 16'sd0;
    xa[63] = -16'sd1;
    frame("imp63", -63, -1, 0, 0);

    fill(16'sd2, 16'sd3);
    frame("gap", 384, 10, 20, 1);

    fill(16'sd0, 16'sd0);
    for (int i = 0; i < 64; i++) ba[i] = 16'(i + 1);
    xa[0] = 16'sd7;
    frame("idx0", 7, -1, 0, 0);

    // Abort a frame with reset on the 30th compute edge.
    fill(16'sd2, 16'sd3);
    load(-1, 0);
    repeat (29) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_sum", sum, 0);
    chk("abort_able", able2write_out, 1);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (sum !== 38'sd0) n++;
    end
    chk("abort_no_update", n, 0);

    fill(16'sd1, -16'sd1);
    frame("negones", -64, -1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_mac_core.md
Name: fir_mac_core

Overview:
- 64-tap, 16-bit signed FIR output engine.
- Accepts a frame of 64 (sample X, coefficient B) pairs over a write handshake.
- Computes the dot product sum = Σ X[i]·B[i] with one serial MAC per cycle, then presents the 38-bit result.
- The upstream feeder supplies coefficients already tap-reversed and a sample window per output, so each frame yields one FIR output sample.

Parameters:
- TAPS, 64, pairs per frame and MAC iterations per output.
- DATA_W, 16, width of X and B (signed two's complement).
- SUM_W, 38, accumulator/result width = 2·DATA_W + log2(TAPS); overflow impossible.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- X  in  DATA_W  signed sample, sampled when a write is accepted.
- B  in  DATA_W  signed coefficient, sampled with X.
- in_write_ctrlX  in  1  write strobe; one pair per cycle while high.
- able2write_out  out  1  high = core is in LOAD and accepts pairs.
- sum  out  SUM_W  signed registered result of the last completed frame.

Behaviour:
- Reset (reset==0 at a rising edge): state=LOAD, wr_ptr=0, acc=0, sum=0, able2write_out=1.
  - Buffer contents are don't-care.
  - Reset mid-LOAD or mid-COMPUTE aborts the frame; sum is not updated.
- Accepted write = in_write_ctrlX & able2write_out at a rising edge.
- LOAD state:
  - Each accepted write stores {X,B} at index wr_ptr and increments wr_ptr.
  - in_write_ctrlX low pauses loading; wr_ptr and stored pairs are held indefinitely, so gaps are legal.
  - The write at wr_ptr==TAPS-1 is edge E0. At E0, wr_ptr wraps to 0, state goes to COMPUTE, able2write_out goes to 0, and acc clears to 0.
- COMPUTE state:
  - Edges E1..E64 each do acc += sext(X[k])·sext(B[k]), k = 0..63.
  - The product is full 32-bit signed, sign-extended to SUM_W.
  - in_write_ctrlX is ignored; no buffer writes occur.
  - At E64 the final term is added and sum is loaded with the complete result. At the same edge state returns to LOAD and able2write_out goes to 1.
  - Latency: sum is valid 64 cycles after the last accepted write.
- sum holds its value until the next frame completes; it changes only at E64.
- A strobe asserted in the same cycle able2write_out rises (after E64) is accepted and becomes index 0 of the next frame.
- No saturation or rounding: the exact sum is always representable in 38 bits.

Decomposition:
- Shared package fir_pkg: TAPS, DATA_W, SUM_W, PTR_W = log2(TAPS), and a state enum {LOAD, COMPUTE}.
- One natural sub-module: fir_mac (signed DATA_W×DATA_W multiply plus SUM_W accumulator with clear/enable).
- Sample/coefficient storage stays in the top as two TAPS×DATA_W register arrays with a shared index.

Test Plan:
- All 64 pairs X=1, B=1 written back-to-back from reset → able2write_out low for 64 cycles, then sum=64 and able2write_out=1 on the same edge.
- Extremes:
  - X=32767, B=32767 for all pairs → sum=68715282496.
  - X=-32768, B=-32768 → sum=68719476736.
  - X=-32768, B=32767 → sum=-68717379584.
- Impulse: X[5]=1, all other X=0, B[i]=i → sum=5. A second frame with X[63]=-1 → sum=-63; sum stays 5 until that frame's E64.
- Gapped writes: 10 pairs, strobe low for 20 cycles, then 54 pairs (all X=2, B=3) → sum=384. Strobes held high during COMPUTE → ignored, no corruption; the next frame starts at index 0.
- Reset pulse at E30 of COMPUTE → sum=0 and able2write_out=1 after reset. A fresh frame of all X=1, B=-1 → sum=-64.
- reset held low with strobe active → no writes accepted; sum=0 throughout.
